// File: rtl/led_pulse_stretcher.sv
// Per-channel LED pulse stretcher: event -> lit interval -> enforced dark gap, one event queued per channel.
// Outputs registered, LED lights the cycle after the event; events beyond the single queue slot are dropped and flagged.
module led_pulse_stretcher #(
   parameter int WIDTH          = 1,
   parameter int SAMPLE_CNT_MAX = 25000,
   parameter int ON_CNT_MAX     = 500,
   parameter int OFF_CNT_MAX    = 250
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] busy,
   output logic [WIDTH-1:0] dropped
);

   localparam int SW   = $clog2(SAMPLE_CNT_MAX);
   localparam int HMAX = (ON_CNT_MAX > OFF_CNT_MAX) ? ON_CNT_MAX : OFF_CNT_MAX;
   localparam int HW   = (HMAX > 1) ? $clog2(HMAX) : 1;

   localparam logic [SW-1:0] SAMPLE_LAST = SW'(SAMPLE_CNT_MAX - 1);
   localparam logic [HW-1:0] ON_LAST     = HW'(ON_CNT_MAX - 1);
   localparam logic [HW-1:0] OFF_LAST    = HW'(OFF_CNT_MAX - 1);

   typedef enum logic [1:0] {IDLE, ON, OFF} state_t;

   logic [SW-1:0]    sample_cnt;
   logic             tick;
   state_t           state_q   [WIDTH];
   state_t           state_d   [WIDTH];
   logic [HW-1:0]    hold_q    [WIDTH];
   logic [HW-1:0]    hold_d    [WIDTH];
   logic [WIDTH-1:0] pending_q;
   logic [WIDTH-1:0] pending_d;
   logic [WIDTH-1:0] dropped_d;

   assign tick = (sample_cnt == SAMPLE_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         sample_cnt <= '0;
         pending_q  <= '0;
         out        <= '0;
         busy       <= '0;
         dropped    <= '0;
         for (int i = 0; i < WIDTH; i++) begin
            state_q[i] <= IDLE;
            hold_q[i]  <= '0;
         end
      end else begin
         sample_cnt <= tick ? '0 : sample_cnt + 1'b1;
         pending_q  <= pending_d;
         dropped    <= dropped_d;
         for (int i = 0; i < WIDTH; i++) begin
            state_q[i] <= state_d[i];
            hold_q[i]  <= hold_d[i];
            out[i]     <= (state_d[i] == ON);
            busy[i]    <= (state_d[i] != IDLE);
         end
      end
   end

   always_comb begin
      for (int i = 0; i < WIDTH; i++) begin
         state_d[i]   = state_q[i];
         hold_d[i]    = hold_q[i];
         pending_d[i] = pending_q[i];
         dropped_d[i] = 1'b0;

         case (state_q[i])
            IDLE: begin
               if (in[i]) begin
                  state_d[i] = ON;
                  hold_d[i]  = '0;
               end
            end
            ON: begin
               if (tick) begin
                  if (hold_q[i] == ON_LAST) begin
                     state_d[i] = OFF;
                     hold_d[i]  = '0;
                  end else begin
                     hold_d[i] = hold_q[i] + 1'b1;
                  end
               end
               if (in[i]) begin
                  if (pending_q[i]) dropped_d[i] = 1'b1;
                  else              pending_d[i] = 1'b1;
               end
            end
            OFF: begin
               if (tick && hold_q[i] == OFF_LAST) begin
                  // Exit cycle: a queued event wins, a simultaneous new one takes its slot.
                  if (pending_q[i] || in[i]) begin
                     state_d[i]   = ON;
                     hold_d[i]    = '0;
                     pending_d[i] = pending_q[i] & in[i];
                  end else begin
                     state_d[i] = IDLE;
                     hold_d[i]  = '0;
                  end
               end else begin
                  if (tick) hold_d[i] = hold_q[i] + 1'b1;
                  if (in[i]) begin
                     if (pending_q[i]) dropped_d[i] = 1'b1;
                     else              pending_d[i] = 1'b1;
                  end
               end
            end
            default: begin
               state_d[i] = IDLE;
               hold_d[i]  = '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_led_pulse_stretcher.sv
// Scoreboard bench for led_pulse_stretcher with WIDTH=2, SAMPLE_CNT_MAX=4, ON_CNT_MAX=3, OFF_CNT_MAX=2.
module tb_led_pulse_stretcher;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] in;
   logic [1:0] out;
   logic [1:0] busy;
   logic [1:0] dropped;

   int n_checks = 0;
   int n_errors = 0;
   logic [5:0] exp_q[$];

   always #5 clk = ~clk;

   led_pulse_stretcher #(
      .WIDTH(2),
      .SAMPLE_CNT_MAX(4),
      .ON_CNT_MAX(3),
      .OFF_CNT_MAX(2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .in(in),
      .out(out),
      .busy(busy),
      .dropped(dropped)
   );

   task automatic check(input string tag, input logic [5:0] act, input logic [5:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: {dropped,busy,out} got %b expected %b", tag, act, exp);
      end
   endtask

   function automatic bit inr(input int c, input int a, input int b);
      return (c >= a) && (c <= b);
   endfunction

   // {rst, in[1:0]} driven during cycle c
   function automatic logic [2:0] stim(input int scn, input int c);
      logic [2:0] s;
      s = 3'b000;
      case (scn)
         0: if (c == 1) s = 3'b001;
         1: if (c == 1 || c == 5) s = 3'b001;
         2: if (c == 1 || c == 5 || c == 6) s = 3'b001;
         3: if (c == 1 || c == 19) s = 3'b001;
         4: if (c == 3) s = 3'b010;
         5: begin
            if (c == 1 || c == 5 || c == 9) s = 3'b001;
            if (c == 6 || c == 7) s = 3'b100;
         end
         default: s = 3'b000;
      endcase
      return s;
   endfunction

   // Expected {dropped[1:0], busy[1:0], out[1:0]} in cycle c, taken from the timing plan.
   function automatic logic [5:0] expect_at(input int scn, input int c);
      bit o0, b0, d0, o1, b1;
      o0 = 0; b0 = 0; d0 = 0; o1 = 0; b1 = 0;
      case (scn)
         0: begin o0 = inr(c, 2, 11); b0 = inr(c, 2, 19); end
         1, 3: begin o0 = inr(c, 2, 11) || inr(c, 20, 31); b0 = inr(c, 2, 39); end
         2: begin o0 = inr(c, 2, 11) || inr(c, 20, 31); b0 = inr(c, 2, 39); d0 = (c == 7); end
         4: begin o1 = inr(c, 4, 15); b1 = inr(c, 4, 23); end
         5: begin o0 = inr(c, 2, 6) || inr(c, 10, 19); b0 = inr(c, 2, 6) || inr(c, 10, 27); end
         default: ;
      endcase
      return {1'b0, d0, b1, b0, o1, o0};
   endfunction

   task automatic run_scenario(input int scn, input int ncyc);
      logic [5:0] act;
      logic [5:0] exp;
      rst = 1'b1;
      in  = 2'b00;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.push_back(expect_at(scn, 0));
      for (int c = 0; c < ncyc; c++) begin
         act = {dropped, busy, out};
         exp = exp_q.pop_front();
         check($sformatf("scn%0d cyc%0d", scn, c), act, exp);
         {rst, in} = stim(scn, c);
         exp_q.push_back(expect_at(scn, c + 1));
         @(posedge clk);
         #1;
      end
      in  = 2'b00;
      rst = 1'b0;
      exp_q.delete();
   endtask

   initial begin
      rst = 1'b1;
      in  = 2'b00;
      run_scenario(0, 45);
      run_scenario(1, 45);
      run_scenario(2, 45);
      run_scenario(3, 45);
      run_scenario(4, 45);
      run_scenario(5, 55);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
